// File: rtl/tex_csr_ctrl_pkg.sv
// Shared texture types: per-stage CSR record, field offsets, commit FSM states.
// Also holds the field-write helper used by the shadow copy.
package tex_csr_ctrl_pkg;

  localparam int TEX_LOD_MAX     = 7;
  localparam int TEX_MIPOFF_BITS = 20;
  localparam int TEX_LOGDIM_BITS = 4;
  localparam int TEX_WRAP_BITS   = 2;
  localparam int TEX_FORMAT_BITS = 3;
  localparam int TEX_FILTER_BITS = 2;

  localparam int TEX_CSR_ADDR        = 'h00;
  localparam int TEX_CSR_FORMAT      = 'h01;
  localparam int TEX_CSR_FILTER      = 'h02;
  localparam int TEX_CSR_WRAP_U      = 'h03;
  localparam int TEX_CSR_WRAP_V      = 'h04;
  localparam int TEX_CSR_LOGDIM_U    = 'h05;
  localparam int TEX_CSR_LOGDIM_V    = 'h06;
  localparam int TEX_CSR_MIPOFF_BASE = 'h10;

  typedef struct packed {
    logic [TEX_LOD_MAX:0][TEX_MIPOFF_BITS-1:0] mipoff;
    logic [1:0][TEX_LOGDIM_BITS-1:0]           logdim;
    logic [1:0][TEX_WRAP_BITS-1:0]             wrap;
    logic [31:0]                               baddr;
    logic [TEX_FORMAT_BITS-1:0]                format;
    logic [TEX_FILTER_BITS-1:0]                filter;
  } tex_csrs_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT
  } tex_cfg_state_t;

  function automatic tex_csrs_t tex_csr_write(
    tex_csrs_t   r,
    logic [31:0] addr,
    logic [31:0] data
  );
    tex_csrs_t n;
    n = r;
    case (addr)
      32'(TEX_CSR_ADDR):     n.baddr     = data;
      32'(TEX_CSR_FORMAT):   n.format    = data[TEX_FORMAT_BITS-1:0];
      32'(TEX_CSR_FILTER):   n.filter    = data[TEX_FILTER_BITS-1:0];
      32'(TEX_CSR_WRAP_U):   n.wrap[0]   = data[TEX_WRAP_BITS-1:0];
      32'(TEX_CSR_WRAP_V):   n.wrap[1]   = data[TEX_WRAP_BITS-1:0];
      32'(TEX_CSR_LOGDIM_U): n.logdim[0] = data[TEX_LOGDIM_BITS-1:0];
      32'(TEX_CSR_LOGDIM_V): n.logdim[1] = data[TEX_LOGDIM_BITS-1:0];
      default: begin
        // unmapped offsets fall through untouched
        for (int i = 0; i <= TEX_LOD_MAX; i++) begin
          if (addr == 32'(TEX_CSR_MIPOFF_BASE + i))
            n.mipoff[i] = data[TEX_MIPOFF_BITS-1:0];
        end
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tex_csr_ctrl_if.sv
// CSR write, commit, texture request/response and active-config bundle.
// master = core/issue side, slave = tex_csr_ctrl.
interface tex_csr_ctrl_if #(
  parameter int NUM_STAGES    = 2,
  parameter int CSR_ADDR_BITS = 8
);
  import tex_csr_ctrl_pkg::*;

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                     csr_wr_valid;
  logic [SW-1:0]            csr_wr_stage;
  logic [CSR_ADDR_BITS-1:0] csr_wr_addr;
  logic [31:0]              csr_wr_data;
  logic                     csr_wr_ready;

  logic                     commit_valid;
  logic [SW-1:0]            commit_stage;
  logic                     commit_ready;
  logic                     commit_done;

  logic                     req_valid;
  logic [SW-1:0]            req_stage;
  logic                     req_ready;

  logic                     rsp_fire;
  logic [SW-1:0]            rsp_stage;

  tex_csrs_t [NUM_STAGES-1:0] tex_csrs;

  modport master (
    output csr_wr_valid, csr_wr_stage, csr_wr_addr, csr_wr_data,
    input  csr_wr_ready,
    output commit_valid, commit_stage,
    input  commit_ready, commit_done,
    output req_valid, req_stage,
    input  req_ready,
    output rsp_fire, rsp_stage,
    input  tex_csrs
  );

  modport slave (
    input  csr_wr_valid, csr_wr_stage, csr_wr_addr, csr_wr_data,
    output csr_wr_ready,
    input  commit_valid, commit_stage,
    output commit_ready, commit_done,
    input  req_valid, req_stage,
    output req_ready,
    input  rsp_fire, rsp_stage,
    output tex_csrs
  );

endinterface

// File: rtl/tex_pending_ctr.sv
// Per-stage in-flight request counter, saturating at 0 and MAX_PENDING.
module tex_pending_ctr #(
  parameter int MAX_PENDING = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int CW = $clog2(MAX_PENDING + 1);

  logic [CW-1:0] cnt;

  assign full  = (cnt == CW'(MAX_PENDING));
  assign empty = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (inc && !dec && !full)
      cnt <= cnt + 1'b1;
    else if (dec && !inc && !empty)
      cnt <= cnt - 1'b1;
  end

  // a response with nothing in flight means the issue logic lost track
  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(dec && empty));
  end

endmodule

// File: rtl/tex_csr_ctrl.sv
// Shadow/active texture config per stage; commit swaps only once a stage drains.
module tex_csr_ctrl
  import tex_csr_ctrl_pkg::*;
#(
  parameter int NUM_STAGES    = 2,
  parameter int MAX_PENDING   = 16,
  parameter int CSR_ADDR_BITS = 8
) (
  input logic         clk,
  input logic         reset,
  tex_csr_ctrl_if.slave bus
);

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  tex_cfg_state_t state, state_n;
  logic [SW-1:0]  cstage, cstage_n;

  logic [NUM_STAGES-1:0] full;
  logic [NUM_STAGES-1:0] empty;

  tex_csrs_t [NUM_STAGES-1:0] shadow;
  tex_csrs_t [NUM_STAGES-1:0] active;

  logic locked;
  logic draining;
  logic wr_fire;
  logic req_fire;

  assign locked   = (state != ST_IDLE);
  assign draining = (state == ST_DRAIN);

  assign bus.csr_wr_ready = !(locked && bus.csr_wr_stage == cstage);
  assign bus.req_ready    = !full[bus.req_stage] &&
                            !(draining && bus.req_stage == cstage);

  assign wr_fire  = bus.csr_wr_valid && bus.csr_wr_ready;
  assign req_fire = bus.req_valid && bus.req_ready;

  assign bus.tex_csrs = active;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    tex_pending_ctr #(
      .MAX_PENDING(MAX_PENDING)
    ) u_ctr (
      .clk  (clk),
      .reset(reset),
      .inc  (req_fire && bus.req_stage == SW'(s)),
      .dec  (bus.rsp_fire && bus.rsp_stage == SW'(s)),
      .full (full[s]),
      .empty(empty[s])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cstage <= '0;
    end else begin
      state  <= state_n;
      cstage <= cstage_n;
    end
  end

  always_comb begin
    state_n          = state;
    cstage_n         = cstage;
    bus.commit_ready = 1'b0;
    bus.commit_done  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bus.commit_ready = 1'b1;
        if (bus.commit_valid) begin
          cstage_n = bus.commit_stage;
          state_n  = empty[bus.commit_stage] ? ST_COMMIT : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (empty[cstage])
          state_n = ST_COMMIT;
      end
      ST_COMMIT: begin
        bus.commit_done = 1'b1;
        state_n         = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      shadow <= '0;
    else if (wr_fire)
      shadow[bus.csr_wr_stage] <= tex_csr_write(
        shadow[bus.csr_wr_stage],
        32'(bus.csr_wr_addr),
        bus.csr_wr_data
      );
  end

  // writes to cstage are held off, so shadow is stable through COMMIT
  always_ff @(posedge clk) begin
    if (reset)
      active <= '0;
    else if (state == ST_COMMIT)
      active[cstage] <= shadow[cstage];
  end

endmodule

// File: tb/tb_tex_csr_ctrl.sv
// Directed + random bench for tex_csr_ctrl against a transaction-level model.
module tb_tex_csr_ctrl;
  import tex_csr_ctrl_pkg::*;

  localparam int NS   = 2;
  localparam int MAXP = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tex_csr_ctrl_if #(.NUM_STAGES(NS), .CSR_ADDR_BITS(8)) bus();

  tex_csr_ctrl #(
    .NUM_STAGES(NS),
    .MAX_PENDING(MAXP),
    .CSR_ADDR_BITS(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  tex_csrs_t m_sh  [NS];
  tex_csrs_t m_act [NS];
  int        m_pend[NS];
  bit        m_busy;
  bit        m_copy;
  int        m_bs;

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic tex_csrs_t mwrite(tex_csrs_t r, int a, logic [31:0] d);
    tex_csrs_t n = r;
    if (a == 0)      n.baddr     = d;
    else if (a == 1) n.format    = d[2:0];
    else if (a == 2) n.filter    = d[1:0];
    else if (a == 3) n.wrap[0]   = d[1:0];
    else if (a == 4) n.wrap[1]   = d[1:0];
    else if (a == 5) n.logdim[0] = d[3:0];
    else if (a == 6) n.logdim[1] = d[3:0];
    else if (a >= 16 && a <= 16 + TEX_LOD_MAX) n.mipoff[a-16] = d[19:0];
    return n;
  endfunction

  task automatic mreset();
    for (int s = 0; s < NS; s++) begin
      m_sh[s]   = '0;
      m_act[s]  = '0;
      m_pend[s] = 0;
    end
    m_busy = 0;
    m_copy = 0;
    m_bs   = 0;
  endtask

  task automatic idle_inputs();
    bus.csr_wr_valid = 0; bus.csr_wr_stage = 0;
    bus.csr_wr_addr  = 0; bus.csr_wr_data  = 0;
    bus.commit_valid = 0; bus.commit_stage = 0;
    bus.req_valid    = 0; bus.req_stage    = 0;
    bus.rsp_fire     = 0; bus.rsp_stage    = 0;
  endtask

  // check outputs against model, then advance model across one edge
  task automatic tick();
    int  ws, rs, ps, cs;
    bit  e_wr, e_cr, e_done, e_rr, wf, rf, cf;
    ws = int'(bus.csr_wr_stage);
    rs = int'(bus.req_stage);
    ps = int'(bus.rsp_stage);
    cs = int'(bus.commit_stage);
    #1;
    e_wr   = !(m_busy && ws == m_bs);
    e_cr   = !m_busy;
    e_done = m_busy && m_copy;
    e_rr   = (m_pend[rs] < MAXP) && !(m_busy && !m_copy && rs == m_bs);
    chk("csr_wr_ready", 256'(bus.csr_wr_ready), 256'(e_wr));
    chk("commit_ready", 256'(bus.commit_ready), 256'(e_cr));
    chk("commit_done",  256'(bus.commit_done),  256'(e_done));
    chk("req_ready",    256'(bus.req_ready),    256'(e_rr));
    for (int s = 0; s < NS; s++)
      chk($sformatf("tex_csrs[%0d]", s), 256'(bus.tex_csrs[s]), 256'(m_act[s]));
    @(posedge clk);
    if (reset) begin
      mreset();
    end else begin
      wf = bus.csr_wr_valid && e_wr;
      rf = bus.req_valid && e_rr;
      cf = bus.commit_valid && e_cr;
      if (m_busy && m_copy) begin
        m_act[m_bs] = m_sh[m_bs];
        m_busy = 0;
        m_copy = 0;
      end else if (m_busy && m_pend[m_bs] == 0) begin
        m_copy = 1;
      end
      if (cf) begin
        m_busy = 1;
        m_bs   = cs;
        m_copy = (m_pend[cs] == 0);
      end
      if (wf) m_sh[ws] = mwrite(m_sh[ws], int'(bus.csr_wr_addr), bus.csr_wr_data);
      for (int s = 0; s < NS; s++) begin
        bit inc, dec;
        inc = rf && rs == s;
        dec = bus.rsp_fire && ps == s;
        if (inc && !dec) m_pend[s]++;
        else if (dec && !inc && m_pend[s] > 0) m_pend[s]--;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    tex_csrs_t exp5;
    int        got;
    mreset();
    idle_inputs();
    reset = 1;
    @(negedge clk);
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_commit_ready", 256'(bus.commit_ready), 256'(1));
    chk("rst_csr_wr_ready", 256'(bus.csr_wr_ready), 256'(1));
    chk("rst_req_ready",    256'(bus.req_ready),    256'(1));
    chk("rst_commit_done",  256'(bus.commit_done),  256'(0));

    // 1: shadow write invisible until commit
    bus.csr_wr_valid = 1; bus.csr_wr_stage = 0;
    bus.csr_wr_addr = 8'h00; bus.csr_wr_data = 32'h8000_0040;
    tick();
    bus.csr_wr_addr = 8'h01; bus.csr_wr_data = 32'h2;
    tick();
    bus.csr_wr_valid = 0;
    tick();
    chk("t1_no_commit", 256'(bus.tex_csrs[0]), 256'(0));
    bus.commit_valid = 1; bus.commit_stage = 0;
    tick();
    bus.commit_valid = 0;
    #1 chk("t1_done_t1", 256'(bus.commit_done), 256'(1));
    chk("t1_not_yet", 256'(bus.tex_csrs[0].baddr), 256'(0));
    tick();
    chk("t1_baddr",  256'(bus.tex_csrs[0].baddr),  256'(32'h8000_0040));
    chk("t1_format", 256'(bus.tex_csrs[0].format), 256'(2));

    // 2: commit waits for stage-1 drain
    bus.req_valid = 1; bus.req_stage = 1;
    tick(); tick(); tick();
    bus.req_valid = 0;
    bus.commit_valid = 1; bus.commit_stage = 1;
    tick();
    bus.commit_valid = 0;
    bus.req_valid = 1; bus.req_stage = 1;
    #1 chk("t2_req1_blocked", 256'(bus.req_ready), 256'(0));
    bus.req_stage = 0;
    #1 chk("t2_req0_open", 256'(bus.req_ready), 256'(1));
    bus.req_valid = 0;
    bus.rsp_fire = 1; bus.rsp_stage = 1;
    tick(); tick(); tick();
    bus.rsp_fire = 0;
    chk("t2_done_early", 256'(bus.commit_done), 256'(0));
    tick();
    chk("t2_done", 256'(bus.commit_done), 256'(1));
    tick();

    // 3: pending counter saturation at MAX_PENDING
    bus.req_valid = 1; bus.req_stage = 0;
    for (int i = 0; i < MAXP; i++) tick();
    #1 chk("t3_full", 256'(bus.req_ready), 256'(0));
    tick();
    chk("t3_still_full", 256'(bus.req_ready), 256'(0));
    bus.req_valid = 0;
    bus.rsp_fire = 1; bus.rsp_stage = 0;
    tick();
    bus.req_valid = 1;
    tick();
    chk("t3_req_rsp_same", 256'(bus.req_ready), 256'(1));
    bus.req_valid = 0;
    for (int i = 0; i < 13; i++) tick();
    bus.rsp_fire = 0;

    // 4: stage-0 writes stall during its drain, stage 1 unaffected
    bus.commit_valid = 1; bus.commit_stage = 0;
    tick();
    bus.commit_valid = 0;
    bus.csr_wr_valid = 1; bus.csr_wr_stage = 0;
    bus.csr_wr_addr = 8'h02; bus.csr_wr_data = 32'h3;
    #1 chk("t4_s0_blocked", 256'(bus.csr_wr_ready), 256'(0));
    bus.csr_wr_stage = 1; bus.csr_wr_addr = 8'h00;
    bus.csr_wr_data = 32'hCAFE_0000;
    #1 chk("t4_s1_open", 256'(bus.csr_wr_ready), 256'(1));
    tick();
    bus.csr_wr_stage = 0; bus.csr_wr_addr = 8'h02;
    bus.csr_wr_data = 32'h3;
    bus.rsp_fire = 1; bus.rsp_stage = 0;
    tick(); tick();
    bus.rsp_fire = 0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      #1;
      if (bus.csr_wr_ready) got = 1;
      tick();
    end
    chk("t4_wr_accept_bound", 256'(got), 256'(1));
    bus.csr_wr_valid = 0;

    // 5: last mip level and an unmapped offset
    exp5 = m_sh[0];
    exp5.mipoff[TEX_LOD_MAX] = 20'hABCDE;
    bus.csr_wr_valid = 1; bus.csr_wr_stage = 0;
    bus.csr_wr_addr = 8'(16 + TEX_LOD_MAX); bus.csr_wr_data = 32'h000A_BCDE;
    tick();
    bus.csr_wr_addr = 8'h0F; bus.csr_wr_data = 32'hFFFF_FFFF;
    #1 chk("t5_unmapped_ack", 256'(bus.csr_wr_ready), 256'(1));
    tick();
    bus.csr_wr_valid = 0;
    bus.commit_valid = 1; bus.commit_stage = 0;
    tick();
    bus.commit_valid = 0;
    tick();
    chk("t5_mipoff_only", 256'(bus.tex_csrs[0]), 256'(exp5));

    // 6: reset in the middle of a drain
    bus.req_valid = 1; bus.req_stage = 0;
    tick(); tick();
    bus.req_valid = 0;
    bus.commit_valid = 1; bus.commit_stage = 0;
    tick();
    bus.commit_valid = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("t6_commit_ready", 256'(bus.commit_ready), 256'(1));
    chk("t6_commit_done",  256'(bus.commit_done),  256'(0));
    chk("t6_tex_csrs",     256'(bus.tex_csrs),     256'(0));
    bus.req_valid = 1; bus.req_stage = 0;
    #1 chk("t6_req_ready", 256'(bus.req_ready), 256'(1));
    bus.req_valid = 0;
    tick();

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      int a, ps;
      a = int'($urandom_range(0, 9));
      if (a < 7) a = a;
      else if (a == 7) a = 'h0F;
      else a = 16 + int'($urandom_range(0, TEX_LOD_MAX));
      bus.csr_wr_valid = ($urandom_range(0, 2) == 0);
      bus.csr_wr_stage = 1'($urandom_range(0, NS - 1));
      bus.csr_wr_addr  = 8'(a);
      bus.csr_wr_data  = $urandom;
      bus.commit_valid = ($urandom_range(0, 5) == 0);
      bus.commit_stage = 1'($urandom_range(0, NS - 1));
      bus.req_valid    = ($urandom_range(0, 1) == 0);
      bus.req_stage    = 1'($urandom_range(0, NS - 1));
      ps = int'($urandom_range(0, NS - 1));
      bus.rsp_stage    = 1'(ps);
      bus.rsp_fire     = (m_pend[ps] > 0) && ($urandom_range(0, 2) != 0);
      reset            = ($urandom_range(0, 150) == 0);
      tick();
    end
    reset = 0;
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
